// File: rtl/softmax_tile_packer.sv
// softmax_tile_packer: packs a scalar element stream into tiles.
// Define SOFTMAX_PACK_PAD_NEG_EN to pad with the most-negative value.
module softmax_tile_packer #(
  parameter int WIDTH          = 32,
  parameter int TILE_SIZE      = 16,
  parameter int TOTAL_ELEMENTS = 1024,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           elem_in,
  input  logic                       elem_valid,
  output logic                       elem_ready,
  output logic [TILE_SIZE*WIDTH-1:0] X_tile_out,
  output logic                       tile_out_valid,
  input  logic                       tile_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int TW = TILE_SIZE * WIDTH;
  localparam int LW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam int CW = $clog2(TOTAL_ELEMENTS + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

`ifdef SOFTMAX_PACK_PAD_NEG_EN
  localparam logic [WIDTH-1:0] PAD = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] PAD = '0;
`endif
  localparam logic [TW-1:0] PAD_TILE = {TILE_SIZE{PAD}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [CW-1:0]   e_cnt_q, e_cnt_d;
  logic [TW-1:0]   asm_q, asm_d;
  logic [TW-1:0]   mem_q [FIFO_DEPTH];
  logic [TW-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [NW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            push;
  logic            pop;
  logic            last_lane;
  logic            last_elem;
  logic            restart;
  logic [TW-1:0]   tile_w;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign elem_ready = (state_q == S_FILL)
                   && (cnt_q < NW'(FIFO_DEPTH));
  assign tile_out_valid = (cnt_q != '0);
  assign X_tile_out = tile_out_valid ? mem_q[rd_q] : '0;
  assign busy = (state_q == S_FILL)
             || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  assign accept    = elem_valid && elem_ready;
  assign last_lane = (lane_q == LW'(TILE_SIZE - 1));
  assign last_elem = (e_cnt_q == CW'(TOTAL_ELEMENTS - 1));
  assign push      = accept && (last_lane || last_elem);
  assign pop       = tile_out_valid && tile_ready;
  assign restart   = start
                  && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Assembly register with the incoming element merged into its lane
  always_comb begin
    tile_w = asm_q;
    for (int k = 0; k < TILE_SIZE; k++) begin
      if (lane_q == LW'(k)) begin
        tile_w[(TILE_SIZE-1-k)*WIDTH +: WIDTH] = elem_in;
      end
    end
  end

  // Next state of the vector sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FILL;
      S_DONE:  if (start) state_d = S_FILL;
      S_FILL:  if (accept && last_elem) state_d = S_DRAIN;
      S_DRAIN: if (pop && cnt_q == NW'(1)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane/element counters, tile assembly and completed-tile FIFO
  always_comb begin
    lane_d  = lane_q;
    e_cnt_d = e_cnt_q;
    asm_d   = asm_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (restart) begin
      lane_d  = '0;
      e_cnt_d = '0;
      asm_d   = PAD_TILE;
    end
    if (accept) begin
      lane_d  = lane_q + LW'(1);
      e_cnt_d = e_cnt_q + CW'(1);
      asm_d   = tile_w;
    end
    if (push) begin
      asm_d       = PAD_TILE;
      lane_d      = '0;
      mem_d[wr_q] = tile_w;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q);
    end
    unique case (1'b1)
      (push && !pop): cnt_d = cnt_q + NW'(1);
      (pop && !push): cnt_d = cnt_q - NW'(1);
      default:        cnt_d = cnt_q;
    endcase
  end

  // State registers; reset drops any partial or buffered tiles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      e_cnt_q <= '0;
      asm_q   <= PAD_TILE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      e_cnt_q <= e_cnt_d;
      asm_q   <= asm_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

endmodule
